// File: rtl/fir_output_stage.sv
// -----------------------------------------------------------------------------
// fir_output_stage
//
// Output stage of the FIR datapath. Every time the datapath pulses its
// sum-ready strobe, the wide accumulator value is captured, scaled back to
// sample width with round-half-up, saturated, and written into a small
// circular FIFO. Samples leave the FIFO over a valid/ready handshake.
// Results that arrive while the FIFO is full and not draining are dropped,
// and a sticky flag records that this happened.
//
// Ports:
//   i_clk              clock; all state changes on the rising edge
//   i_rst              synchronous, active-high reset
//   i_sum_in           signed accumulator value (sum_width bits)
//   i_sum_ready        one-cycle strobe; i_sum_in is valid in the same cycle
//   i_clear_overflow   clears the sticky overflow flag
//   o_out_data         signed output sample at the head of the FIFO
//   o_out_valid        FIFO is not empty
//   i_out_ready        downstream accepts o_out_data this cycle
//   o_fifo_full        FIFO holds fifo_depth entries
//   o_overflow         sticky: at least one result has been dropped
//   o_sat_event        pulse: the sample handled this cycle was clamped
//
// Handshake: a transfer happens on a rising edge where o_out_valid and
// i_out_ready are both high. While o_out_valid is high and i_out_ready is
// low, o_out_data is held stable. o_out_valid never drops without a transfer
// except on reset.
//
// Timing: a strobe sampled at edge N puts the rounded value into stage 1;
// edge N+1 saturates it and writes it into the FIFO, so o_out_valid (if the
// FIFO was empty) and o_sat_event are visible right after edge N+1. There is
// no fall-through from the write path to o_out_data.
// -----------------------------------------------------------------------------
module fir_output_stage #(
  parameter int bit_width  = 16,
  parameter int FIR_order  = 64,
  parameter int fifo_depth = 4
) (
  input  logic                                            i_clk,
  input  logic                                            i_rst,
  input  logic [2*bit_width+$clog2(FIR_order)-1:0]        i_sum_in,
  input  logic                                            i_sum_ready,
  input  logic                                            i_clear_overflow,
  output logic [bit_width-1:0]                            o_out_data,
  output logic                                            o_out_valid,
  input  logic                                            i_out_ready,
  output logic                                            o_fifo_full,
  output logic                                            o_overflow,
  output logic                                            o_sat_event
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int SUM_W = 2*bit_width + $clog2(FIR_order);
  // Rounded value after the shift by (bit_width-1): one guard bit on top of
  // the accumulator, minus the discarded fraction bits.
  localparam int S1_W  = SUM_W + 1 - (bit_width - 1);
  localparam int HI_W  = S1_W - (bit_width - 1);
  localparam int PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int CNT_W = $clog2(fifo_depth + 1);

  // Half an output LSB in accumulator scale: adding it before truncation
  // gives round-half-up.
  localparam logic [SUM_W:0] RND_C = {{SUM_W{1'b0}}, 1'b1} << (bit_width - 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(fifo_depth);

  // ---------------------------------------------------------------------------
  // Stage 1: rounding
  // ---------------------------------------------------------------------------
  logic [SUM_W:0]   w_rounded;
  logic [S1_W-1:0]  w_shifted;
  logic             w_unused_lsbs;

  logic [S1_W-1:0]  r_s1;
  logic             r_v1;

  // One extra sign bit keeps the add from wrapping for the most positive
  // accumulator values.
  assign w_rounded = {i_sum_in[SUM_W-1], i_sum_in} + RND_C;

  // Arithmetic shift right by (bit_width-1) is just the upper slice of the
  // sign-extended sum; the fraction bits are discarded.
  assign w_shifted     = w_rounded[SUM_W:bit_width-1];
  assign w_unused_lsbs = ^w_rounded[bit_width-2:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1 <= 1'b0;
      r_s1 <= '0;
    end else begin
      r_v1 <= i_sum_ready;
      if (i_sum_ready) begin
        r_s1 <= w_shifted;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: saturation
  // ---------------------------------------------------------------------------
  logic             w_s1_sign;
  logic [HI_W-1:0]  w_s1_hi;
  logic             w_sat_pos;
  logic             w_sat_neg;
  logic [bit_width-1:0] w_sat_val;

  // The value fits in bit_width bits only when the top HI_W bits are all
  // copies of the sign bit.
  assign w_s1_sign = r_s1[S1_W-1];
  assign w_s1_hi   = r_s1[S1_W-1:bit_width-1];
  assign w_sat_pos = !w_s1_sign && (|w_s1_hi);
  assign w_sat_neg =  w_s1_sign && !(&w_s1_hi);

  always_comb begin
    w_sat_val = r_s1[bit_width-1:0];
    if (w_sat_pos) begin
      w_sat_val = {1'b0, {(bit_width-1){1'b1}}};
    end else if (w_sat_neg) begin
      w_sat_val = {1'b1, {(bit_width-1){1'b0}}};
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [bit_width-1:0] r_mem [fifo_depth];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_overflow;
  logic                 r_sat_event;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);
  assign w_pop   = !w_empty && i_out_ready;

  // A pop in the same cycle frees the slot the write needs, so a full FIFO
  // that is draining still accepts the new sample.
  assign w_push  = r_v1 && (!w_full || w_pop);
  assign w_drop  = r_v1 && w_full && !w_pop;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_sat_val;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Status flags
  // ---------------------------------------------------------------------------
  // A drop in the same cycle as a clear request leaves the flag set, so no
  // drop can go unreported.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (i_clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  // Pulses for clamped samples whether they were written or dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sat_event <= 1'b0;
    end else begin
      r_sat_event <= r_v1 && (w_sat_pos || w_sat_neg);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Forced to zero while empty so the stale memory contents never show.
  assign o_out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_out_valid = !w_empty;
  assign o_fifo_full = w_full;
  assign o_overflow  = r_overflow;
  assign o_sat_event = r_sat_event;

endmodule

// File: tb/tb_fir_output_stage.sv
// -----------------------------------------------------------------------------
// tb_fir_output_stage
//
// Directed bench for fir_output_stage with default parameters
// (bit_width=16, FIR_order=64, fifo_depth=4, sum_width=38). Inputs change
// 1 time unit after a rising edge and outputs are sampled at the same point,
// well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_fir_output_stage;

  localparam int BW    = 16;
  localparam int SUM_W = 38;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic             clk;
  logic             rst;
  logic [SUM_W-1:0] sum_in;
  logic             sum_ready;
  logic             clear_overflow;
  logic [BW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic             fifo_full;
  logic             overflow;
  logic             sat_event;

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fir_output_stage #(
    .bit_width (BW),
    .FIR_order (64),
    .fifo_depth(4)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_sum_in        (sum_in),
    .i_sum_ready     (sum_ready),
    .i_clear_overflow(clear_overflow),
    .o_out_data      (out_data),
    .o_out_valid     (out_valid),
    .i_out_ready     (out_ready),
    .o_fifo_full     (fifo_full),
    .o_overflow      (overflow),
    .o_sat_event     (sat_event)
  );

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    sum_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_fifo_full got=%b exp=0", fifo_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (sat_event !== 1'b0) begin errors++; $display("FAIL reset_sat_event got=%b exp=0", sat_event); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    sum_ready = 1'b1;
    sum_in    = 38'(16384);
    tick();
    sum_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early_valid got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 16'h0001) begin errors++; $display("FAIL latency_data got=%h exp=0001", out_data); end
    checks++; if (sat_event !== 1'b0) begin errors++; $display("FAIL latency_sat got=%b exp=0", sat_event); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_popped got=%b exp=0", out_valid); end
  endtask

  // Rounding and saturation vectors share one stream: each is strobed,
  // checked two edges later, then popped.
  task automatic test_rounding_saturation();
    longint        vin  [7];
    logic [BW-1:0] vexp [7];
    logic          vsat [7];
    vin[0] = 16383;            vexp[0] = 16'h0000; vsat[0] = 1'b0;
    vin[1] = -16384;           vexp[1] = 16'h0000; vsat[1] = 1'b0;
    vin[2] = -16385;           vexp[2] = 16'hFFFF; vsat[2] = 1'b0;
    vin[3] = 49152;            vexp[3] = 16'h0002; vsat[3] = 1'b0;
    vin[4] = 64'd2147483648;   vexp[4] = 16'h7FFF; vsat[4] = 1'b1;
    vin[5] = -64'd2147483648;  vexp[5] = 16'h8000; vsat[5] = 1'b1;
    vin[6] = 32767 * 32768;    vexp[6] = 16'h7FFF; vsat[6] = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      sum_ready = 1'b1;
      sum_in    = 38'(vin[i]);
      tick();
      sum_ready = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL vec%0d_valid got=%b exp=1", i, out_valid); end
      checks++; if (out_data !== vexp[i]) begin errors++; $display("FAIL vec%0d_data got=%h exp=%h", i, out_data, vexp[i]); end
      checks++; if (sat_event !== vsat[i]) begin errors++; $display("FAIL vec%0d_sat got=%b exp=%b", i, sat_event, vsat[i]); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL vec_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      sum_ready = 1'b1;
      sum_in    = 38'(k * 32768);
      tick();
      // Strobe k lands in the FIFO one edge later; the 4th write is at edge 5
      // and result 5 is dropped at edge 6.
      checks++; if (fifo_full !== (k >= 5)) begin errors++; $display("FAIL bp_full_k%0d got=%b exp=%b", k, fifo_full, (k >= 5)); end
      checks++; if (overflow !== (k >= 6)) begin errors++; $display("FAIL bp_ovf_k%0d got=%b exp=%b", k, overflow, (k >= 6)); end
    end
    sum_ready = 1'b0;
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf_after got=%b exp=1", overflow); end
    checks++; if (out_data !== 16'd1) begin errors++; $display("FAIL bp_hold_data got=%0d exp=1", out_data); end
    tick();
    checks++; if (out_data !== 16'd1) begin errors++; $display("FAIL bp_hold_data2 got=%0d exp=1", out_data); end
    out_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid%0d got=%b exp=1", j, out_valid); end
      checks++; if (out_data !== 16'(j)) begin errors++; $display("FAIL bp_drain_data%0d got=%0d exp=%0d", j, out_data, j); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [BW-1:0] exp_q[$];
    int            budget;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      sum_ready = 1'b1;
      sum_in    = 38'(c * 32768);
      exp_q.push_back(16'(c));
      out_ready = (c >= 6);
      if (c >= 6) begin
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fpp_full_c%0d got=%b exp=1", c, fifo_full); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL fpp_extra got=%0d exp=none", out_data);
        end else if (out_data !== exp_q[0]) begin
          errors++; $display("FAIL fpp_order got=%0d exp=%0d", out_data, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      tick();
    end
    sum_ready = 1'b0;
    out_ready = 1'b1;
    budget    = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      if (out_valid) begin
        checks++;
        if (out_data !== exp_q[0]) begin
          errors++; $display("FAIL fpp_order_tail got=%0d exp=%0d", out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      tick();
      budget--;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fpp_timeout left=%0d exp=0", exp_q.size()); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow got=%b exp=0", overflow); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_overflow_control();
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      sum_ready = 1'b1;
      sum_in    = 38'(k * 32768);
      tick();
    end
    sum_ready = 1'b0;
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovc_set got=%b exp=1", overflow); end

    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovc_clear got=%b exp=0", overflow); end

    // Saturating sample dropped in the same cycle as a clear request.
    sum_ready = 1'b1;
    sum_in    = 38'(64'd2147483648);
    tick();
    sum_ready      = 1'b0;
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovc_set_wins got=%b exp=1", overflow); end
    checks++; if (sat_event !== 1'b1) begin errors++; $display("FAIL ovc_sat_on_drop got=%b exp=1", sat_event); end
    checks++; if (out_data !== 16'd1) begin errors++; $display("FAIL ovc_head got=%0d exp=1", out_data); end
    tick();
    checks++; if (sat_event !== 1'b0) begin errors++; $display("FAIL ovc_sat_pulse got=%b exp=0", sat_event); end

    // Leave three entries buffered and one in flight, then reset.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL ovc_three got=%b exp=0", fifo_full); end
    sum_ready = 1'b1;
    sum_in    = 38'(7 * 32768);
    tick();
    sum_ready = 1'b0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf got=%b exp=0", overflow); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL rst_mid_data got=%h exp=0000", out_data); end
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale_t%0d got=%b exp=0", t, out_valid); end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    rst            = 1'b1;
    sum_in         = '0;
    sum_ready      = 1'b0;
    clear_overflow = 1'b0;
    out_ready      = 1'b0;
    test_reset();
    test_latency();
    test_rounding_saturation();
    test_back_pressure();
    test_full_push_pop();
    test_overflow_control();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
